clk_divider_prog: RTL and testbench

//   Runtime-programmable integer clock divider; next generation of the fixed-DIV divider.

---
 rtl/clk_divider_prog.sv | 111 +++++++++++
 tb/tb_clk_divider_prog.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider.
// Produces a registered square wave (clk_out) and a one-cycle strobe (tick) on each
// rising phase. A new divisor is taken through a ready/load handshake and is applied
// only on a period boundary, so a period is never shortened by a ratio change.
// A request captured on a wrap edge waits for the following boundary. Illegal
// divisors (< 2) are rejected on the edge after capture.

module clk_divider_prog #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_rdy,
    output logic             div_ack,
    output logic             div_err,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             boundary;
    logic             pend_legal;
    logic             reject;
    logic             apply;
    logic             capture;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] hi;

    // Next-state: counter, handshake and registered waveform outputs
    always_comb begin
        boundary   = (cnt_q == (div_cur_q - One));
        pend_legal = (div_pend_q >= MinDiv);
        // Only the registered pending value is judged, so a capture edge never applies it
        reject     = pend_q && !pend_legal;
        apply      = pend_q && pend_legal && boundary;
        capture    = div_load && !pend_q;
        div_next   = apply ? div_pend_q : div_cur_q;
        hi         = div_next >> 1;

        cnt_d      = cnt_q;
        div_cur_d  = div_next;
        div_pend_d = capture ? div_in : div_pend_q;
        pend_d     = pend_q;
        ack_d      = reject || apply;
        err_d      = reject;

        if (reject || apply) begin
            pend_d = 1'b0;
        end else if (capture) begin
            pend_d = 1'b1;
        end

        if (en) begin
            cnt_d = boundary ? '0 : (cnt_q + One);
        end else begin
            // Parked at the last count so the next enable starts a fresh period
            cnt_d = div_next - One;
        end

        clk_out_d = en && (cnt_d < hi);
        tick_d    = en && (cnt_d == '0);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q      <= DefDiv - One;
            div_cur_q  <= DefDiv;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign div_rdy = !pend_q;
    assign div_ack = ack_q;
    assign div_err = err_q;
    assign div_cur = div_cur_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: waveform shapes, handshake timing, park and reset.

module tb_clk_divider_prog;

    localparam int unsigned CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             div_rdy;
    logic             div_ack;
    logic             div_err;
    logic [CNT_W-1:0] div_cur;
    logic             clk_out;
    logic             tick;

    int n_vec  = 0;
    int n_miss = 0;

    // Sampled outputs, first sample ends up in the highest used bit
    logic [31:0] wave_co;
    logic [31:0] wave_tk;
    logic [31:0] wave_ak;

    clk_divider_prog #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(4)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .div_in  (div_in),
        .div_load(div_load),
        .div_rdy (div_rdy),
        .div_ack (div_ack),
        .div_err (div_err),
        .div_cur (div_cur),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 time unit after each
    task automatic cycles(input int n);
        wave_co = '0;
        wave_tk = '0;
        wave_ak = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            wave_co = {wave_co[30:0], clk_out};
            wave_tk = {wave_tk[30:0], tick};
            wave_ak = {wave_ak[30:0], div_ack};
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        div_in   = '0;
        div_load = 1'b0;

        // Reset state
        cycles(3);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_div_cur", 32'(div_cur), 32'd4);
        check("rst_rdy", 32'(div_rdy), 32'd1);
        check("rst_ack", 32'(div_ack), 32'd0);

        // Default divisor 4: 1100 repeating, tick on each rise
        rst = 1'b0;
        en  = 1'b1;
        cycles(8);
        check("t1_clk_out", wave_co, 32'b11001100);
        check("t1_tick", wave_tk, 32'b10001000);
        check("t1_ack", wave_ak, 32'd0);
        check("t1_div_cur", 32'(div_cur), 32'd4);
        check("t1_rdy", 32'(div_rdy), 32'd1);

        // Illegal divisor 1: rejected one edge after capture, waveform untouched
        div_in   = 16'd1;
        div_load = 1'b1;
        cycles(1);
        check("t3_rdy_busy", 32'(div_rdy), 32'd0);
        check("t3_ack_early", 32'(div_ack), 32'd0);
        div_load = 1'b0;
        cycles(1);
        check("t3_ack", 32'(div_ack), 32'd1);
        check("t3_err", 32'(div_err), 32'd1);
        check("t3_rdy_back", 32'(div_rdy), 32'd1);
        check("t3_div_cur", 32'(div_cur), 32'd4);
        check("t3_clk_hold", 32'(clk_out), 32'd1);
        cycles(6);
        check("t3_clk_out", wave_co, 32'b001100);
        check("t3_no_ack", wave_ak, 32'd0);

        // Mid-period load of 7 completes the 4-cycle period first
        cycles(2);
        div_in   = 16'd7;
        div_load = 1'b1;
        cycles(1);
        check("t2_rdy_busy", 32'(div_rdy), 32'd0);
        div_load = 1'b0;
        cycles(1);
        check("t2_ack_wait", 32'(div_ack), 32'd0);
        check("t2_div_old", 32'(div_cur), 32'd4);
        check("t2_clk_low", 32'(clk_out), 32'd0);
        cycles(14);
        check("t2_clk_out", wave_co, 32'b11100001110000);
        check("t2_tick", wave_tk, 32'b10000001000000);
        check("t2_ack", wave_ak, 32'b10000000000000);
        check("t2_div_cur", 32'(div_cur), 32'd7);
        check("t2_err", 32'(div_err), 32'd0);
        check("t2_rdy", 32'(div_rdy), 32'd1);

        // Load 9 on a wrap edge, then 3 while busy: 3 ignored, 9 applied next boundary
        div_in   = 16'd9;
        div_load = 1'b1;
        cycles(1);
        check("t4_rdy_busy", 32'(div_rdy), 32'd0);
        check("t4_wrap_tick", 32'(tick), 32'd1);
        div_in = 16'd3;
        cycles(1);
        check("t4_ignored_ack", 32'(div_ack), 32'd0);
        div_load = 1'b0;
        cycles(24);
        check("t4_clk_out", wave_co, 32'b100001111000001111000001);
        check("t4_ack_once", wave_ak, 32'b000001000000000000000000);
        check("t4_div_cur", 32'(div_cur), 32'd9);
        check("t4_rdy", 32'(div_rdy), 32'd1);

        // Park with a load of 6: output held low, ack on the edge after capture
        en       = 1'b0;
        div_in   = 16'd6;
        div_load = 1'b1;
        cycles(1);
        check("t5_park_clk", 32'(clk_out), 32'd0);
        div_load = 1'b0;
        cycles(9);
        check("t5_park_wave", wave_co, 32'd0);
        check("t5_park_ack", wave_ak, 32'b100000000);
        check("t5_div_cur", 32'(div_cur), 32'd6);
        en = 1'b1;
        cycles(7);
        check("t5_clk_out", wave_co, 32'b1110001);
        check("t5_tick", wave_tk, 32'b1000001);

        // Reset in the high phase with a load pending discards it
        div_in   = 16'd10;
        div_load = 1'b1;
        cycles(1);
        check("t6_high", 32'(clk_out), 32'd1);
        check("t6_busy", 32'(div_rdy), 32'd0);
        div_load = 1'b0;
        rst      = 1'b1;
        cycles(1);
        check("t6_clk_out", 32'(clk_out), 32'd0);
        check("t6_div_cur", 32'(div_cur), 32'd4);
        check("t6_rdy", 32'(div_rdy), 32'd1);
        check("t6_ack", 32'(div_ack), 32'd0);
        rst = 1'b0;
        cycles(8);
        check("t6_after_wave", wave_co, 32'b11001100);
        check("t6_after_ack", wave_ak, 32'd0);
        check("t6_after_div", 32'(div_cur), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
